spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter_if.sv | 26 ++
 rtl/spi_arbiter.sv | 167 ++++++++++++++++
 tb/tb_spi_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arbiter_if.sv
// Bus bundle between the SPI arbiter, its three requesters and the SPI master.
// The arbiter uses the slave modport; the requester/master side uses the master modport.
interface spi_arbiter_if;
    logic [2:0]  req;
    logic [23:0] tx_data;
    logic [2:0]  gnt;
    logic [2:0]  ack;
    logic [7:0]  rx_data;
    logic        err;
    logic        busy;
    logic        m_start;
    logic [1:0]  m_slave_sel;
    logic [7:0]  m_mosi_data;
    logic        m_done;
    logic [7:0]  m_miso_data;

    modport slave (
        input  req, tx_data, m_done, m_miso_data,
        output gnt, ack, rx_data, err, busy, m_start, m_slave_sel, m_mosi_data
    );

    modport master (
        output req, tx_data, m_done, m_miso_data,
        input  gnt, ack, rx_data, err, busy, m_start, m_slave_sel, m_mosi_data
    );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among three requesters, one byte per grant.
// Define SPI_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles without m_done.
//
//   state | meaning
//   IDLE  | no transaction, picking a winner when any req is high
//   START | one-cycle m_start strobe to the SPI master
//   WAIT  | waiting for m_done (or the timeout, when enabled)
//   ACK   | one-cycle ack pulse to the owner, gnt clears on exit
module spi_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic         clk,
    input logic         rst,
    spi_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] first, second, third, winner;
    logic [2:0] gnt_q, gnt_d;
    logic [2:0] ack_q, ack_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] mosi_q, mosi_d;
    logic       busy_q, busy_d;
    logic       start_q, start_d;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        logic [2:0] v;
        case (idx)
            2'd0:    v = 3'b001;
            2'd1:    v = 3'b010;
            default: v = 3'b100;
        endcase
        return v;
    endfunction

    // Search order starts just after the previous winner and wraps mod 3.
    always_comb begin
        first  = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        second = (first  == 2'd2) ? 2'd0 : first  + 2'd1;
        third  = (second == 2'd2) ? 2'd0 : second + 2'd1;
        if (bus.req[first])
            winner = first;
        else if (bus.req[second])
            winner = second;
        else
            winner = third;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ack_d   = 3'b000;
        rx_d    = rx_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        start_d = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req != 3'b000) begin
                    state_d = START;
                    last_d  = winner;
                    sel_d   = winner;
                    gnt_d   = onehot(winner);
                    mosi_d  = bus.tx_data[{winner, 3'b000} +: 8];
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
            end
            WAIT: begin
                if (bus.m_done) begin
                    state_d = ACK;
                    ack_d   = gnt_q;
                    rx_d    = bus.m_miso_data;
`ifdef SPI_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == TC_LAST) begin
                    state_d = ACK;
                    ack_d   = gnt_q;
                    rx_d    = 8'hFF;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
`endif
                end
            end
            ACK: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 2'd2;
            sel_q   <= 2'd0;
            gnt_q   <= 3'b000;
            ack_q   <= 3'b000;
            rx_q    <= 8'h00;
            mosi_q  <= 8'h00;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rx_q    <= rx_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            start_q <= start_d;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.ack         = ack_q;
    assign bus.rx_data     = rx_q;
    assign bus.busy        = busy_q;
    assign bus.m_start     = start_q;
    assign bus.m_slave_sel = sel_q;
    assign bus.m_mosi_data = mosi_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign bus.err         = err_q;
`else
    assign bus.err         = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed table, reset/timeout sequences and
// randomized transactions against a round-robin reference model.
module tb_spi_arbiter;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TC = 8;
`else
    localparam int TC = 64;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_arbiter_if bus_if ();

    spi_arbiter #(.TIMEOUT_CYCLES(TC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;
    int last_m = 2;

    typedef struct {
        logic [2:0]  req;
        logic [23:0] tx;
        logic [7:0]  miso;
        int          exp_w;
        logic [7:0]  exp_mosi;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference arbitration: first requesting index after the previous winner, mod 3.
    function automatic int model_pick(input logic [2:0] r);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (last_m + k) % 3;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_gnt"},   bus_if.gnt, 0);
        chk({nm, "_ack"},   bus_if.ack, 0);
        chk({nm, "_rx"},    bus_if.rx_data, 0);
        chk({nm, "_err"},   bus_if.err, 0);
        chk({nm, "_busy"},  bus_if.busy, 0);
        chk({nm, "_start"}, bus_if.m_start, 0);
        chk({nm, "_sel"},   bus_if.m_slave_sel, 0);
        chk({nm, "_mosi"},  bus_if.m_mosi_data, 0);
    endtask

    // Entered in an IDLE cycle with req/tx_data already driven; leaves in the following IDLE cycle.
    task automatic run_txn(input int w, input logic [7:0] mosi, input logic [7:0] miso,
                           input int dly, input bit early_done, input bit scramble,
                           input logic [2:0] next_req);
        logic [2:0] oh;
        oh = 3'b001 << w;
        tick();
        chk("start_strobe", bus_if.m_start, 1);
        chk("start_gnt", bus_if.gnt, oh);
        chk("start_sel", bus_if.m_slave_sel, w);
        chk("start_mosi", bus_if.m_mosi_data, mosi);
        chk("start_busy", bus_if.busy, 1);
        chk("start_ack", bus_if.ack, 0);
        if (early_done) begin
            bus_if.m_done = 1'b1;
            bus_if.m_miso_data = ~miso;
        end
        tick();
        bus_if.m_done = 1'b0;
        chk("wait_strobe", bus_if.m_start, 0);
        chk("wait_ack", bus_if.ack, 0);
        for (int i = 0; i < dly; i++) begin
            if (scramble) begin
                bus_if.req = 3'($urandom);
                bus_if.tx_data = 24'($urandom);
            end
            tick();
            chk("hold_ack", bus_if.ack, 0);
            chk("hold_mosi", bus_if.m_mosi_data, mosi);
            chk("hold_sel", bus_if.m_slave_sel, w);
            chk("hold_gnt", bus_if.gnt, oh);
        end
        bus_if.m_done = 1'b1;
        bus_if.m_miso_data = miso;
        tick();
        chk("ack_val", bus_if.ack, oh);
        chk("ack_rx", bus_if.rx_data, miso);
        chk("ack_err", bus_if.err, 0);
        chk("ack_gnt", bus_if.gnt, oh);
        chk("ack_mosi", bus_if.m_mosi_data, mosi);
        chk("ack_sel", bus_if.m_slave_sel, w);
        bus_if.m_done = 1'b0;
        bus_if.m_miso_data = 8'($urandom);
        bus_if.req = next_req;
        tick();
        chk("idle_ack", bus_if.ack, 0);
        chk("idle_gnt", bus_if.gnt, 0);
        chk("idle_busy", bus_if.busy, 0);
        chk("idle_start", bus_if.m_start, 0);
        last_m = w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        logic [2:0]  r;
        logic [23:0] t;

        tbl[0] = '{3'b111, 24'hC3B2A1, 8'h11, 0, 8'hA1};
        tbl[1] = '{3'b110, 24'hC3B2A1, 8'h22, 1, 8'hB2};
        tbl[2] = '{3'b100, 24'hC3B2A1, 8'h33, 2, 8'hC3};
        tbl[3] = '{3'b001, 24'h0000A5, 8'h3C, 0, 8'hA5};
        tbl[4] = '{3'b010, 24'h005A00, 8'h44, 1, 8'h5A};
        tbl[5] = '{3'b011, 24'h006677, 8'h55, 0, 8'h77};
        tbl[6] = '{3'b010, 24'h006677, 8'h66, 1, 8'h66};

        rst = 1'b1;
        bus_if.req = 3'b000;
        bus_if.tx_data = 24'h0;
        bus_if.m_done = 1'b0;
        bus_if.m_miso_data = 8'h0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // m_done while idle must be ignored
        bus_if.m_done = 1'b1;
        bus_if.m_miso_data = 8'h77;
        tick();
        bus_if.m_done = 1'b0;
        chk("idle_done_ack", bus_if.ack, 0);
        chk("idle_done_busy", bus_if.busy, 0);
        chk("idle_done_rx", bus_if.rx_data, 0);

        for (int i = 0; i < 7; i++) begin
            bus_if.req = tbl[i].req;
            bus_if.tx_data = tbl[i].tx;
            run_txn(tbl[i].exp_w, tbl[i].exp_mosi, tbl[i].miso, i % 3, (i == 2), 1'b0,
                    (i < 6) ? tbl[i+1].req : 3'b000);
        end

        // reset in the middle of WAIT abandons the transaction
        bus_if.req = 3'b001;
        bus_if.tx_data = 24'h0000A5;
        tick();
        tick();
        tick();
        rst = 1'b1;
        bus_if.req = 3'b000;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        last_m = 2;
        bus_if.m_done = 1'b1;
        tick();
        bus_if.m_done = 1'b0;
        chk("midrst_noack", bus_if.ack, 0);
        chk("midrst_busy", bus_if.busy, 0);
        bus_if.req = 3'b101;
        bus_if.tx_data = 24'h990011;
        run_txn(model_pick(3'b101), 8'h11, 8'hC4, 1, 1'b0, 1'b0, 3'b000);
        bus_if.req = 3'b100;
        bus_if.tx_data = 24'h990011;
        run_txn(model_pick(3'b100), 8'h99, 8'hD5, 0, 1'b0, 1'b0, 3'b000);

`ifdef SPI_ARB_TIMEOUT_EN
        begin
            int n;
            bus_if.req = 3'b010;
            bus_if.tx_data = 24'h00BB00;
            tick();
            chk("to_start", bus_if.m_start, 1);
            bus_if.req = 3'b000;
            n = 0;
            do begin
                tick();
                n++;
            end while (bus_if.ack == 3'b000 && n <= 20);
            chk("to_cycles", n, TC + 1);
            chk("to_ack", bus_if.ack, 3'b010);
            chk("to_rx", bus_if.rx_data, 8'hFF);
            chk("to_err", bus_if.err, 1);
            tick();
            chk("to_idle_busy", bus_if.busy, 0);
            chk("to_idle_gnt", bus_if.gnt, 0);
            last_m = 1;
        end
`else
        bus_if.req = 3'b010;
        bus_if.tx_data = 24'h00BB00;
        run_txn(model_pick(3'b010), 8'hBB, 8'h5E, 100, 1'b0, 1'b1, 3'b000);
`endif

        for (int k = 0; k < 40; k++) begin
            r = 3'($urandom_range(1, 7));
            t = 24'($urandom);
            w = model_pick(r);
            bus_if.req = r;
            bus_if.tx_data = t;
            run_txn(w, t[8*w +: 8], 8'($urandom), $urandom_range(0, 5),
                    1'($urandom_range(0, 1)), 1'b1, 3'b000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
